// File: rtl/calendar_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calendar_pkg
// Brief   : Shared calendar constants, month enumeration and month-length
//           function used by the date counter, day-of-week and display logic.
// Revision: 1.0 - initial release
// ============================================================================
package calendar_pkg;

   localparam int YEAR_MAX = 99;
   localparam int MONTHS   = 12;

   typedef enum logic [7:0] {
      JAN = 8'd1,  FEB = 8'd2,  MAR = 8'd3,  APR = 8'd4,
      MAY = 8'd5,  JUN = 8'd6,  JUL = 8'd7,  AUG = 8'd8,
      SEP = 8'd9,  OCT = 8'd10, NOV = 8'd11, DEC = 8'd12
   } month_e;

   // Out-of-range months return 0 so that any day check against them fails.
   function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                input logic [7:0] year);
      logic [7:0] days;
      case (month)
         JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = 8'd31;
         APR, JUN, SEP, NOV:                days = 8'd30;
         FEB:     days = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
         default: days = 8'd0;
      endcase
      return days;
   endfunction

endpackage : calendar_pkg
`default_nettype wire

// File: rtl/calendar_counter_month_length.sv
`default_nettype none
// ============================================================================
// Module  : month_length
// Brief   : Combinational days-in-month lookup for a (month, year) pair.
// Revision: 1.0 - initial release
// ============================================================================
module month_length
   import calendar_pkg::*;
(
   input  logic [7:0] month,
   input  logic [7:0] year,
   output logic [7:0] days
);

   // Pure lookup; the shared function keeps every consumer consistent.
   assign days = days_in_month(month, year);

endmodule : month_length
`default_nettype wire

// File: rtl/calendar_counter.sv
`default_nettype none
// ============================================================================
// Module  : calendar_counter
// Brief   : Year/month/day register set advanced by a daily tick, loadable
//           through a validated set request. Set has priority over tick.
// Revision: 1.0 - initial release
// ============================================================================
module calendar_counter
   import calendar_pkg::*;
#(
   parameter int RESET_YEAR  = 0,
   parameter int RESET_MONTH = 1,
   parameter int RESET_DAY   = 1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       day_tick,
   input  logic       set_en,
   input  logic [7:0] set_year,
   input  logic [7:0] set_month,
   input  logic [7:0] set_day,
   output logic [7:0] year,
   output logic [7:0] month,
   output logic [7:0] day,
   output logic       date_changed,
   output logic       set_err
);

   localparam logic [7:0] c_year_max  = 8'(YEAR_MAX);
   localparam logic [7:0] c_months    = 8'(MONTHS);
   localparam logic [7:0] c_rst_year  = 8'(RESET_YEAR);
   localparam logic [7:0] c_rst_month = 8'(RESET_MONTH);
   localparam logic [7:0] c_rst_day   = 8'(RESET_DAY);

   localparam bit c_rst_ok =
      (RESET_YEAR  >= 0) && (RESET_YEAR  <= YEAR_MAX) &&
      (RESET_MONTH >= 1) && (RESET_MONTH <= MONTHS)   &&
      (RESET_DAY   >= 1) &&
      (c_rst_day <= days_in_month(c_rst_month, c_rst_year));

   generate
      if (!c_rst_ok) begin : g_bad_reset_date
         $error("calendar_counter: RESET_YEAR/MONTH/DAY is not a legal date");
      end
   endgenerate

   logic [7:0] r_year, r_month, r_day;
   logic       r_changed, r_err;
   logic [7:0] w_cur_dim, w_set_dim;
   logic       w_set_ok;
   logic [7:0] w_next_year, w_next_month, w_next_day;

   month_length u_cur_len (
      .month (r_month),
      .year  (r_year),
      .days  (w_cur_dim)
   );

   month_length u_set_len (
      .month (set_month),
      .year  (set_year),
      .days  (w_set_dim)
   );

   // An invalid month yields w_set_dim=0, which also fails the day check.
   assign w_set_ok = (set_year  <= c_year_max) &&
                     (set_month >= 8'd1) && (set_month <= c_months) &&
                     (set_day   >= 8'd1) && (set_day   <= w_set_dim);

   // Next date after one tick; >= guards against an out-of-range day.
   always_comb begin
      w_next_year  = r_year;
      w_next_month = r_month;
      w_next_day   = r_day + 8'd1;
      if (r_day >= w_cur_dim) begin
         w_next_day = 8'd1;
         if (r_month >= c_months) begin
            w_next_month = 8'd1;
            w_next_year  = (r_year >= c_year_max) ? 8'd0 : r_year + 8'd1;
         end else begin
            w_next_month = r_month + 8'd1;
         end
      end
   end

   // Priority mux: reset, then set request, then tick, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_year    <= c_rst_year;
         r_month   <= c_rst_month;
         r_day     <= c_rst_day;
         r_changed <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_changed <= 1'b0;
         r_err     <= 1'b0;
         if (set_en) begin
            if (w_set_ok) begin
               r_year    <= set_year;
               r_month   <= set_month;
               r_day     <= set_day;
               r_changed <= 1'b1;
            end else begin
               r_err     <= 1'b1;
            end
         end else if (day_tick) begin
            r_year    <= w_next_year;
            r_month   <= w_next_month;
            r_day     <= w_next_day;
            r_changed <= 1'b1;
         end
      end
   end

   assign year         = r_year;
   assign month        = r_month;
   assign day          = r_day;
   assign date_changed = r_changed;
   assign set_err      = r_err;

endmodule : calendar_counter
`default_nettype wire

// File: tb/tb_calendar_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_calendar_counter
// Brief   : Scoreboard bench for calendar_counter with directed date vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_calendar_counter;

   logic       clk;
   logic       rst_n;
   logic       day_tick;
   logic       set_en;
   logic [7:0] set_year, set_month, set_day;
   logic [7:0] year, month, day;
   logic       date_changed, set_err;

   int n_cmp = 0;
   int n_bad = 0;

   // {year, month, day, date_changed, set_err}
   logic [25:0] exp_q[$];

   calendar_counter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .day_tick     (day_tick),
      .set_en       (set_en),
      .set_year     (set_year),
      .set_month    (set_month),
      .set_day      (set_day),
      .year         (year),
      .month        (month),
      .day          (day),
      .date_changed (date_changed),
      .set_err      (set_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_date(input string name, input logic [7:0] ey,
                             input logic [7:0] em, input logic [7:0] ed,
                             input logic ec, input logic ee);
      n_cmp++;
      if ({year, month, day, date_changed, set_err} !== {ey, em, ed, ec, ee}) begin
         n_bad++;
         $display("FAIL %s: got %0d/%0d/%0d chg=%0b err=%0b, want %0d/%0d/%0d chg=%0b err=%0b",
                  name, year, month, day, date_changed, set_err, ey, em, ed, ec, ee);
      end
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && (date_changed || set_err)) begin
         logic [25:0] e;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: got %0d/%0d/%0d chg=%0b err=%0b, want no pulse",
                     year, month, day, date_changed, set_err);
         end else begin
            e = exp_q.pop_front();
            if ({year, month, day, date_changed, set_err} !== e) begin
               n_bad++;
               $display("FAIL scoreboard: got %0d/%0d/%0d chg=%0b err=%0b, want %0d/%0d/%0d chg=%0b err=%0b",
                        year, month, day, date_changed, set_err,
                        e[25:18], e[17:10], e[9:2], e[1], e[0]);
            end
         end
      end
   end

   // Each task drives for one cycle starting just after a rising edge.
   task automatic do_set(input logic [7:0] y, input logic [7:0] m, input logic [7:0] d,
                         input logic tick, input logic ok,
                         input logic [7:0] ey, input logic [7:0] em, input logic [7:0] ed);
      set_en = 1'b1; set_year = y; set_month = m; set_day = d; day_tick = tick;
      exp_q.push_back({ey, em, ed, ok, ~ok});
      @(posedge clk); #1;
      set_en = 1'b0; day_tick = 1'b0;
   endtask

   task automatic do_tick(input logic [7:0] ey, input logic [7:0] em, input logic [7:0] ed);
      day_tick = 1'b1;
      exp_q.push_back({ey, em, ed, 1'b1, 1'b0});
      @(posedge clk); #1;
      day_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with stimulus held active; it must be ignored.
      rst_n = 1'b0; day_tick = 1'b1; set_en = 1'b1;
      set_year = 8'd50; set_month = 8'd6; set_day = 8'd15;
      #22;
      check_date("reset_state", 8'd0, 8'd1, 8'd1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; day_tick = 1'b0; set_en = 1'b0;
      idle(2);
      check_date("post_reset_hold", 8'd0, 8'd1, 8'd1, 1'b0, 1'b0);

      // Leap-year February, back-to-back ticks.
      do_set(8'd24, 8'd2, 8'd28, 1'b0, 1'b1, 8'd24, 8'd2, 8'd28);
      do_tick(8'd24, 8'd2, 8'd29);
      do_tick(8'd24, 8'd3, 8'd1);
      idle(2);

      // Non-leap February, then reject 29 Feb.
      do_set(8'd23, 8'd2, 8'd28, 1'b0, 1'b1, 8'd23, 8'd2, 8'd28);
      do_tick(8'd23, 8'd3, 8'd1);
      do_set(8'd23, 8'd2, 8'd29, 1'b0, 1'b0, 8'd23, 8'd3, 8'd1);
      idle(2);
      check_date("after_reject", 8'd23, 8'd3, 8'd1, 1'b0, 1'b0);

      // Century wrap and the following tick.
      do_set(8'd99, 8'd12, 8'd31, 1'b0, 1'b1, 8'd99, 8'd12, 8'd31);
      do_tick(8'd0, 8'd1, 8'd1);
      do_tick(8'd0, 8'd1, 8'd2);
      idle(1);

      // Set wins over a simultaneous tick; 10/05/01 must never appear.
      do_set(8'd10, 8'd4, 8'd30, 1'b0, 1'b1, 8'd10, 8'd4, 8'd30);
      do_set(8'd10, 8'd7, 8'd15, 1'b1, 1'b1, 8'd10, 8'd7, 8'd15);
      idle(2);
      check_date("set_priority_hold", 8'd10, 8'd7, 8'd15, 1'b0, 1'b0);

      // Rejected set together with a tick: tick still discarded.
      do_set(8'd10, 8'd13, 8'd1, 1'b1, 1'b0, 8'd10, 8'd7, 8'd15);
      // Other illegal requests.
      do_set(8'd10, 8'd0,  8'd1,  1'b0, 1'b0, 8'd10, 8'd7, 8'd15);
      do_set(8'd10, 8'd5,  8'd0,  1'b0, 1'b0, 8'd10, 8'd7, 8'd15);
      do_set(8'd100, 8'd5, 8'd1,  1'b0, 1'b0, 8'd10, 8'd7, 8'd15);
      do_set(8'd10, 8'd4,  8'd31, 1'b0, 1'b0, 8'd10, 8'd7, 8'd15);
      // Identical-date set still pulses date_changed.
      do_set(8'd10, 8'd7,  8'd15, 1'b0, 1'b1, 8'd10, 8'd7, 8'd15);
      idle(1);

      // Month-end boundaries.
      do_set(8'd21, 8'd4, 8'd30, 1'b0, 1'b1, 8'd21, 8'd4, 8'd30);
      do_tick(8'd21, 8'd5, 8'd1);
      do_set(8'd21, 8'd1, 8'd31, 1'b0, 1'b1, 8'd21, 8'd1, 8'd31);
      do_tick(8'd21, 8'd2, 8'd1);
      do_set(8'd0, 8'd2, 8'd29, 1'b0, 1'b1, 8'd0, 8'd2, 8'd29);
      do_tick(8'd0, 8'd3, 8'd1);
      do_set(8'd21, 8'd11, 8'd30, 1'b0, 1'b1, 8'd21, 8'd11, 8'd30);
      do_tick(8'd21, 8'd12, 8'd1);
      do_tick(8'd21, 8'd12, 8'd2);
      idle(2);

      // Asynchronous reset between clock edges, tick held during reset.
      do_set(8'd50, 8'd6, 8'd15, 1'b0, 1'b1, 8'd50, 8'd6, 8'd15);
      @(negedge clk); #2;
      rst_n = 1'b0; day_tick = 1'b1;
      #1;
      check_date("async_reset", 8'd0, 8'd1, 8'd1, 1'b0, 1'b0);
      idle(2);
      check_date("reset_tick_ignored", 8'd0, 8'd1, 8'd1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; day_tick = 1'b0;
      @(posedge clk); #1;
      do_tick(8'd0, 8'd1, 8'd2);
      idle(3);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_calendar_counter
`default_nettype wire

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 SHALL have parameter RESET_YEAR, default 0, meaning the year loaded at reset (0..99 encodes 2000..2099).
REQ-002 SHALL have parameter RESET_MONTH, default 1, meaning the month loaded at reset (1..12).
REQ-003 SHALL have parameter RESET_DAY, default 1, meaning the day loaded at reset (1..31).
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port day_tick  input  1  one-cycle pulse from the time-of-day counter at 23:59:59 -> 00:00:00 rollover.
REQ-007 SHALL have port set_en  input  1  one-cycle request to load set_year/set_month/set_day.
REQ-008 SHALL have ports set_year, set_month, set_day  input  8 each  binary date to load.
REQ-009 SHALL have ports year, month, day  output  8 each  current binary date; drives the day-of-week stage directly.
REQ-010 SHALL have port date_changed  output  1  one-cycle pulse when year/month/day took a new value.
REQ-011 SHALL have port set_err  output  1  one-cycle pulse when a set request was rejected.

Function
REQ-012 SHALL hold year, month and day in registers; outputs are register outputs, with no combinational path from inputs.
REQ-013 SHALL apply day_tick with 1-cycle latency: the new date appears on the edge that samples day_tick=1.
REQ-014 SHALL compute days-in-month as follows: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; for month 2, 29 if year[1:0]==0, else 28.
REQ-015 SHALL increment day by 1 on a tick when day < days-in-month.
REQ-016 SHALL, on a tick at day == days-in-month with month < 12, set day=1 and month=month+1.
REQ-017 SHALL, on a tick at 31 Dec, set day=1 and month=1, and increment year; year 99 wraps to 0.
REQ-018 SHALL accept a set request only if all hold: set_year <= 99; set_month in 1..12; set_day in 1..days-in-month(set_month, set_year).
REQ-019 SHALL load an accepted set on the edge that samples set_en=1 (1-cycle latency).
REQ-020 SHALL, on a rejected set, leave the date unchanged and pulse set_err on the following cycle.
REQ-021 SHALL give set_en priority when set_en and day_tick are both high: the tick is discarded, not deferred.
REQ-022 SHALL pulse date_changed for exactly one cycle, registered with the update (same edge), on every tick and on every accepted set, including a set to the identical date.
REQ-023 SHALL treat back-to-back ticks on consecutive cycles as independent increments, with no tick lost.
REQ-024 SHALL never present an illegal date (day 0, month 0/13, 31 Apr, 29 Feb in a non-leap year) on its outputs.
REQ-025 SHALL NOT produce any 2-bit-truncation or underflow in intermediate arithmetic; all compares are done at 8 bits.

Reset
REQ-026 SHALL, while rst_n is low, force year=RESET_YEAR, month=RESET_MONTH, day=RESET_DAY, date_changed=0 and set_err=0, independent of clk.
REQ-027 SHALL ignore day_tick and set_en asserted during reset; the first tick sampled after rst_n rises advances from the reset date.
REQ-028 SHALL accept only a legal reset date in parameters; an illegal one is flagged by an elaboration-time check.

Structure
REQ-029 SHALL take from a shared package calendar_pkg: constants YEAR_MAX=99 and MONTHS=12, a month-number enumeration, and a days_in_month(month, year) function, all shared with the day-of-week stage and display logic.
REQ-030 SHALL instantiate one combinational sub-module month_length twice: once for the current date and once for set validation.
REQ-031 SHALL contain no FSM beyond the date registers; control is a priority mux of reset, set, tick and hold.

Verification
REQ-032 Reset with defaults -> year=0, month=1, day=1; date_changed=0; set_err=0.
REQ-033 Set 24/02/28, then tick, tick -> 24/02/29 then 24/03/01; date_changed pulses once per tick.
REQ-034 Set 23/02/28, then tick -> 23/03/01; then set 23/02/29 -> rejected, date stays 23/03/01, set_err pulses one cycle.
REQ-035 Set 99/12/31, then tick -> 00/01/01; then tick on the next cycle -> 00/01/02.
REQ-036 Date 10/04/30, with set_en (10/07/15) and day_tick in the same cycle -> 10/07/15 and a single date_changed pulse; 10/05/01 never appears.
REQ-037 Assert rst_n low mid-run at 50/06/15 between clock edges -> outputs go to 00/01/01 immediately; a tick pulse held during reset has no effect.
